// File: rtl/breath_ramp_if.sv
// Control/status bundle between a tick/enable source and breath_ramp.
// The master drives tick and en; the slave (breath_ramp) returns value, busy and cycle_done.
interface breath_ramp_if #(
    parameter int BITS = 10
);
    logic            tick;
    logic            en;
    logic [BITS-1:0] value;
    logic            busy;
    logic            cycle_done;

    modport master (
        output tick,
        output en,
        input  value,
        input  busy,
        input  cycle_done
    );

    modport slave (
        input  tick,
        input  en,
        output value,
        output busy,
        output cycle_done
    );
endinterface

// File: rtl/breath_ramp.sv
// breath_ramp: breathing-envelope duty generator feeding the LED PWM value input.
// Define BREATH_GAMMA_EN for a square-law output curve; the default output is linear.
module breath_ramp #(
    parameter int BITS   = 10,
    parameter int RANGE  = 999,
    parameter int HOLD   = 0,
    parameter int HOLD_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    breath_ramp_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    localparam logic [BITS-1:0]   LEVEL_ONE = BITS'(1);
    localparam logic [BITS-1:0]   RANGE_M1  = BITS'(RANGE - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    // With HOLD == 0 the dwell states are unreachable, so the wrapped value is never used.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam bit                HAS_HOLD  = (HOLD > 0);

    state_t            state_r;
    state_t            state_next;
    logic [BITS-1:0]   level_r;
    logic [BITS-1:0]   level_next;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_next;
    logic [BITS-1:0]   value_r;
    logic              busy_r;
    logic              done_r;
    logic              done_next;

    function automatic logic [BITS-1:0] shape(input logic [BITS-1:0] lvl);
`ifdef BREATH_GAMMA_EN
        return BITS'(({{BITS{1'b0}}, lvl} * {{BITS{1'b0}}, lvl}) >> BITS);
`else
        return lvl;
`endif
    endfunction

    // Next-state, level and dwell-counter logic; ticks only matter outside IDLE.
    always_comb begin
        state_next = state_r;
        level_next = level_r;
        hold_next  = hold_cnt_r;
        done_next  = 1'b0;
        case (state_r)
            IDLE: begin
                level_next = {BITS{1'b0}};
                hold_next  = {HOLD_W{1'b0}};
                if (bus.en) begin
                    state_next = RISE;
                end else begin
                    state_next = IDLE;
                end
            end
            RISE: begin
                if (bus.tick) begin
                    level_next = level_r + LEVEL_ONE;
                    if (level_r == RANGE_M1) begin
                        state_next = HAS_HOLD ? HOLD_HI : FALL;
                    end else begin
                        state_next = RISE;
                    end
                end else begin
                    state_next = RISE;
                end
            end
            HOLD_HI: begin
                if (bus.tick) begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        hold_next  = {HOLD_W{1'b0}};
                        state_next = FALL;
                    end else begin
                        hold_next  = hold_cnt_r + HOLD_ONE;
                        state_next = HOLD_HI;
                    end
                end else begin
                    state_next = HOLD_HI;
                end
            end
            FALL: begin
                if (bus.tick) begin
                    level_next = level_r - LEVEL_ONE;
                    if (level_r != LEVEL_ONE) begin
                        state_next = FALL;
                    end else if (HAS_HOLD) begin
                        state_next = HOLD_LO;
                    end else begin
                        done_next  = 1'b1;
                        state_next = bus.en ? RISE : IDLE;
                    end
                end else begin
                    state_next = FALL;
                end
            end
            HOLD_LO: begin
                if (bus.tick) begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        hold_next  = {HOLD_W{1'b0}};
                        done_next  = 1'b1;
                        state_next = bus.en ? RISE : IDLE;
                    end else begin
                        hold_next  = hold_cnt_r + HOLD_ONE;
                        state_next = HOLD_LO;
                    end
                end else begin
                    state_next = HOLD_LO;
                end
            end
            default: begin
                state_next = IDLE;
                level_next = {BITS{1'b0}};
                hold_next  = {HOLD_W{1'b0}};
            end
        endcase
    end

    // State and output registers; value is shaped from the previous level so it lags by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            level_r    <= {BITS{1'b0}};
            hold_cnt_r <= {HOLD_W{1'b0}};
            value_r    <= {BITS{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_next;
            level_r    <= level_next;
            hold_cnt_r <= hold_next;
            value_r    <= shape(level_r);
            busy_r     <= (state_next != IDLE);
            done_r     <= done_next;
        end
    end

    assign bus.value      = value_r;
    assign bus.busy       = busy_r;
    assign bus.cycle_done = done_r;

endmodule

// File: tb/tb_breath_ramp.sv
// Bench for breath_ramp: three instances (RANGE=4/HOLD=2, RANGE=4/HOLD=0, RANGE=999/HOLD=0)
// checked every cycle against a tick-count envelope model, plus literal per-tick expectations.
module tb_breath_ramp;

    localparam int R [3] = '{4, 4, 999};
    localparam int H [3] = '{2, 0, 0};

    localparam int EXP0 [26] = '{1, 2, 3, 4, 4, 4, 3, 2, 1, 0, 0, 0,
                                 1, 2, 3, 4, 4, 4, 3, 2, 1, 0, 0, 0, 0, 0};
    localparam int EXP1 [26] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4, 3,
                                 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`ifdef BREATH_GAMMA_EN
    localparam int V512 = 256;
    localparam int V999 = 974;
    localparam int V998 = 972;
`else
    localparam int V512 = 512;
    localparam int V999 = 999;
    localparam int V998 = 998;
`endif

    logic clk;
    logic rst_n;
    logic tick_a;
    logic en_a;
    logic tick_b;
    logic en_b;

    int checks;
    int errors;

    breath_ramp_if #(.BITS(10)) bus0 ();
    breath_ramp_if #(.BITS(10)) bus1 ();
    breath_ramp_if #(.BITS(10)) bus2 ();

    assign bus0.tick = tick_a;
    assign bus0.en   = en_a;
    assign bus1.tick = tick_a;
    assign bus1.en   = en_a;
    assign bus2.tick = tick_b;
    assign bus2.en   = en_b;

    breath_ramp #(.BITS(10), .RANGE(4), .HOLD(2), .HOLD_W(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    breath_ramp #(.BITS(10), .RANGE(4), .HOLD(0), .HOLD_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    breath_ramp #(.BITS(10), .RANGE(999), .HOLD(0), .HOLD_W(8)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s[%0d] got %0d expected %0d", name, idx, got, exp);
        end
    endtask

    function automatic int gamma(input int l);
`ifdef BREATH_GAMMA_EN
        return (l * l) >> 10;
`else
        return l;
`endif
    endfunction

    // Envelope level after n ticks into a breath: up, dwell, down, dwell.
    function automatic int lvl_of(input int r, input int h, input int n);
        if (n <= r) return n;
        if (n <= r + h) return r;
        if (n <= 2 * r + h) return 2 * r + h - n;
        return 0;
    endfunction

    int m_n     [3];
    bit m_act   [3];
    int m_value [3];
    bit m_done  [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_n[i] = 0; m_act[i] = 1'b0; m_value[i] = 0; m_done[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                automatic logic t = (i < 2) ? tick_a : tick_b;
                automatic logic e = (i < 2) ? en_a : en_b;
                m_value[i] = gamma(lvl_of(R[i], H[i], m_n[i]));
                m_done[i]  = 1'b0;
                if (!m_act[i]) begin
                    if (e) begin
                        m_act[i] = 1'b1;
                        m_n[i]   = 0;
                    end
                end else if (t) begin
                    m_n[i]++;
                    if (m_n[i] == 2 * R[i] + 2 * H[i]) begin
                        m_done[i] = 1'b1;
                        m_n[i]    = 0;
                        m_act[i]  = e;
                    end
                end
            end
        end
    end

    wire [9:0] dv [3];
    wire       db [3];
    wire       dd [3];
    assign dv[0] = bus0.value; assign db[0] = bus0.busy; assign dd[0] = bus0.cycle_done;
    assign dv[1] = bus1.value; assign db[1] = bus1.busy; assign dd[1] = bus1.cycle_done;
    assign dv[2] = bus2.value; assign db[2] = bus2.busy; assign dd[2] = bus2.cycle_done;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check("model_value", i, 32'(dv[i]), 32'(m_value[i]));
            check("model_busy", i, 32'(db[i]), 32'(m_act[i]));
            check("model_done", i, 32'(dd[i]), 32'(m_done[i]));
        end
    end

    task automatic tick_once(output int v0, output int v1, output bit d0, output bit d1);
        @(negedge clk); tick_a = 1'b1;
        @(negedge clk); tick_a = 1'b0; d0 = bus0.cycle_done; d1 = bus1.cycle_done;
        @(negedge clk); v0 = bus0.value; v1 = bus1.value;
        @(negedge clk);
    endtask

    initial begin
        int  v0, v1, prev, v;
        bit  d0, d1, mono;
        checks = 0; errors = 0;
        rst_n = 1'b0; tick_a = 1'b0; en_a = 1'b1; tick_b = 1'b0; en_b = 1'b0;

        // Reset held with en and ticks: everything stays quiet.
        repeat (4) tick_once(v0, v1, d0, d1);
        check("rst_value", 0, 32'(v0), 32'd0);
        check("rst_busy", 0, 32'(bus0.busy), 32'd0);
        check("rst_done", 0, 32'(d0), 32'd0);

        // Two breaths, en dropped after the 14th tick (level 2 on the rise for u0).
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 26; k++) begin
            if (k == 14) en_a = 1'b0;
            tick_once(v0, v1, d0, d1);
            check("tick_value_h2", k, 32'(v0), 32'(EXP0[k]));
            check("tick_value_h0", k, 32'(v1), 32'(EXP1[k]));
            check("tick_done_h2", k, 32'(d0), 32'((k == 11) || (k == 23)));
            check("tick_done_h0", k, 32'(d1), 32'((k == 7) || (k == 15)));
        end
        check("idle_busy_h2", 0, 32'(bus0.busy), 32'd0);
        check("idle_busy_h0", 0, 32'(bus1.busy), 32'd0);

        // Async reset in the middle of the fall, then restart.
        en_a = 1'b1;
        repeat (7) tick_once(v0, v1, d0, d1);
        check("pre_rst_h2", 0, 32'(v0), 32'd3);
        check("pre_rst_h0", 0, 32'(v1), 32'd1);
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        check("async_value_h2", 0, 32'(bus0.value), 32'd0);
        check("async_busy_h2", 0, 32'(bus0.busy), 32'd0);
        check("async_value_h0", 0, 32'(bus1.value), 32'd0);
        check("async_busy_h0", 0, 32'(bus1.busy), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        tick_once(v0, v1, d0, d1);
        check("restart_h2", 0, 32'(v0), 32'd1);
        check("restart_h0", 0, 32'(v1), 32'd1);

        // Full-range ramp with a tick every clock.
        @(negedge clk); en_b = 1'b1; tick_b = 1'b1;
        prev = 0; mono = 1'b1;
        for (int j = 1; j <= 1002; j++) begin
            @(negedge clk);
            v = int'(bus2.value);
            if (j <= 1001 && v < prev) mono = 1'b0;
            prev = v;
            if (j == 514)  check("range_512", j, 32'(v), 32'(V512));
            if (j == 1001) check("range_999", j, 32'(v), 32'(V999));
            if (j == 1002) check("range_998", j, 32'(v), 32'(V998));
        end
        check("rise_monotonic", 0, 32'(mono), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
